frame_sequencer: RTL
====================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 16, bytes per frame, range 2..32.
REQ-002 SHALL have parameter DBITS, default 8, bits per UART character.
REQ-003 SHALL have parameter GAP_CYCLES, default 1_000_000, inter-byte timeout in clk cycles, at least 2.
REQ-004 SHALL have port clk, input, 1, rising-edge system clock.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port rx_valid, input, 1, one-cycle pulse marking that a UART character is present.
REQ-007 SHALL have port rx_byte, input, DBITS, received character; valid only while rx_valid=1.
REQ-008 SHALL have port cp_din, output, FRAME_BYTES*DBITS, assembled frame for the coprocessor.
REQ-009 SHALL have port cp_din_valid, output, 1, one-cycle pulse marking that cp_din is complete.
REQ-010 SHALL have port cp_dout, input, FRAME_BYTES*DBITS, coprocessor result.
REQ-011 SHALL have port cp_dout_valid, input, 1, one-cycle pulse marking that cp_dout is valid.
REQ-012 SHALL have port tx_frame, output, FRAME_BYTES*DBITS, latched result for the UART transmitter.
REQ-013 SHALL have port tx_start, output, 1, one-cycle pulse that triggers transmission.
REQ-014 SHALL have port tx_busy, input, 1, high while the transmitter is draining.
REQ-015 SHALL have port byte_count, output, 6, number of bytes collected in the current frame.
REQ-016 SHALL have port busy, output, 1, high in every state except COLLECT.
REQ-017 SHALL have port overrun, output, 1, sticky flag set when a byte is dropped.

Function
REQ-018 SHALL use the states COLLECT, ISSUE, WAIT_CP, SEND and DRAIN.
REQ-019 In COLLECT, each rx_valid SHALL store rx_byte at bits [DBITS*(n+1)-1 : DBITS*n], where n = byte_count, and SHALL then increment byte_count; the first byte of a frame lands in [DBITS-1:0].
REQ-020 When the byte that makes byte_count reach FRAME_BYTES is stored, the FSM SHALL go to ISSUE on the next edge.
REQ-021 In ISSUE, the block SHALL drive cp_din_valid=1 for exactly one cycle with cp_din stable, clear byte_count to 0, and go to WAIT_CP.
REQ-022 cp_din SHALL hold its value from ISSUE until the next frame starts filling.
REQ-023 In WAIT_CP, on cp_dout_valid the block SHALL capture cp_dout into tx_frame and go to SEND.
REQ-024 A cp_dout_valid seen in any state other than WAIT_CP SHALL be ignored.
REQ-025 In SEND, the block SHALL pulse tx_start for one cycle and go to DRAIN.
REQ-026 In DRAIN, the FSM SHALL return to COLLECT on the first cycle with tx_busy=0, but no earlier than 2 cycles after tx_start.
REQ-027 Latency SHALL be: cp_din_valid asserted 2 cycles after the edge that samples the final rx_valid; tx_start asserted 2 cycles after the edge that samples cp_dout_valid.
REQ-028 An rx_valid that arrives in any state other than COLLECT SHALL be dropped and SHALL set overrun=1.
REQ-029 overrun SHALL clear only on reset.
REQ-030 tx_frame SHALL hold its value until the next capture.
REQ-031 byte_count SHALL never exceed FRAME_BYTES and SHALL never wrap.

Reset
REQ-032 While reset is high at a clk edge, the block SHALL enter COLLECT and zero byte_count, cp_din, tx_frame, cp_din_valid, tx_start, overrun and the gap counter.
REQ-033 A reset taken mid-frame or mid-transaction SHALL discard all partial data, and no pulse SHALL be emitted on the cycle after reset deasserts.

Configuration
REQ-034 When macro FRAME_SEQ_GAP_TIMEOUT_EN is defined, the block SHALL count cycles in COLLECT while 0 < byte_count < FRAME_BYTES, restarting the count on each rx_valid.
REQ-035 With FRAME_SEQ_GAP_TIMEOUT_EN defined, when the count reaches GAP_CYCLES the block SHALL clear byte_count to 0 (partial frame discarded) without touching overrun.
REQ-036 With FRAME_SEQ_GAP_TIMEOUT_EN defined, an rx_valid on the same cycle as the timeout SHALL be stored as byte 0 of a new frame.
REQ-037 When FRAME_SEQ_GAP_TIMEOUT_EN is undefined, the block SHALL contain no gap counter and a partial frame SHALL persist indefinitely.

Verification
REQ-038 Bench SHALL cover: 16 bytes 0x00..0x0F with 10-cycle spacing -> one cp_din_valid pulse, cp_din=0x0F0E..0100, byte_count back to 0.
REQ-039 Bench SHALL cover: cp_dout=0xA5 repeated, cp_dout_valid 7 cycles after cp_din_valid, tx_busy held 50 cycles -> one tx_start 2 cycles after capture, tx_frame=0xA5A5.., busy drops once tx_busy=0.
REQ-040 Bench SHALL cover: rx_valid while in WAIT_CP -> byte not stored, overrun=1 and still 1 after the next complete frame.
REQ-041 Bench SHALL cover: reset asserted after 9 bytes, then 16 bytes 0x10..0x1F -> cp_din=0x1F1E..1110, with no stale data.
REQ-042 Bench SHALL cover, with FRAME_SEQ_GAP_TIMEOUT_EN and GAP_CYCLES=100: 5 bytes, idle 100 cycles, then 16 bytes -> first 5 discarded, exactly one cp_din_valid containing the 16 new bytes.
REQ-043 Bench SHALL cover: cp_dout_valid in COLLECT -> no tx_start, tx_frame unchanged.

Source files
------------

// File: rtl/frame_sequencer.sv
// frame_sequencer: collects UART characters into a fixed-size frame and hands
// the frame to a coprocessor. It then latches the coprocessor result, starts the
// UART transmitter and waits for the transmitter to drain before it accepts the
// next frame.
//
// Parameters:
//   FRAME_BYTES  bytes per frame (2..32)
//   DBITS        bits per UART character
//   GAP_CYCLES   inter-byte timeout in clk cycles (>= 2)
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   rx_valid, rx_byte      one-cycle character strobe and character
//   cp_din, cp_din_valid   assembled frame and its one-cycle completion pulse
//   cp_dout, cp_dout_valid coprocessor result and its one-cycle strobe
//   tx_frame, tx_start     latched result and one-cycle transmit trigger
//   tx_busy                transmitter still draining
//   byte_count             bytes collected in the current frame
//   busy                   high whenever a new byte cannot be accepted (not COLLECT)
//   overrun                sticky: a byte was dropped; cleared only by reset
//
// Build option: define FRAME_SEQ_GAP_TIMEOUT_EN to discard a partial frame after
// GAP_CYCLES idle cycles between bytes. Without it a partial frame waits forever.
module frame_sequencer #(
  parameter int unsigned FRAME_BYTES = 16,
  parameter int unsigned DBITS       = 8,
  parameter int unsigned GAP_CYCLES  = 1_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rx_valid,
  input  logic [DBITS-1:0]             rx_byte,
  output logic [FRAME_BYTES*DBITS-1:0] cp_din,
  output logic                         cp_din_valid,
  input  logic [FRAME_BYTES*DBITS-1:0] cp_dout,
  input  logic                         cp_dout_valid,
  output logic [FRAME_BYTES*DBITS-1:0] tx_frame,
  output logic                         tx_start,
  input  logic                         tx_busy,
  output logic [5:0]                   byte_count,
  output logic                         busy,
  output logic                         overrun
);

  localparam int unsigned FrameW    = FRAME_BYTES * DBITS;
  localparam logic [5:0]  FullCount = 6'(FRAME_BYTES);

  if (FRAME_BYTES < 2 || FRAME_BYTES > 32) begin : g_bad_frame_bytes
    $error("frame_sequencer: FRAME_BYTES must be in 2..32");
  end
  if (GAP_CYCLES < 2) begin : g_bad_gap_cycles
    $error("frame_sequencer: GAP_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    StCollect,
    StIssue,
    StWaitCp,
    StSend,
    StDrain
  } state_e;

  state_e            state_q, state_d;
  logic [5:0]        count_q, count_d;
  logic [5:0]        count_eff;
  logic [FrameW-1:0] frame_q, frame_d;
  logic [FrameW-1:0] result_q, result_d;
  logic              din_valid_q, din_valid_d;
  logic              start_q, start_d;
  logic              overrun_q, overrun_d;
  logic              armed_q, armed_d;

`ifdef FRAME_SEQ_GAP_TIMEOUT_EN
  localparam int unsigned GapW = $clog2(GAP_CYCLES);

  logic [GapW-1:0] gap_q, gap_d;
  logic            in_window;
  logic            gap_timeout;

  // Idle cycles since the last stored byte, only while a partial frame exists.
  always_comb begin
    in_window   = (state_q == StCollect) && (count_q != '0) && (count_q < FullCount);
    gap_timeout = in_window && (gap_q == GapW'(GAP_CYCLES - 1));
    gap_d       = '0;
    if (in_window && !gap_timeout && !rx_valid) begin
      gap_d = gap_q + GapW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

  // A timeout discards the partial frame; a byte arriving on that same cycle
  // becomes byte 0 of the next frame.
  assign count_eff = gap_timeout ? '0 : count_q;
`else
  assign count_eff = count_q;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    frame_d     = frame_q;
    result_d    = result_q;
    din_valid_d = 1'b0;
    start_d     = 1'b0;
    overrun_d   = overrun_q;
    armed_d     = armed_q;

    unique case (state_q)
      StCollect: begin
        count_d = count_eff;
        if (rx_valid) begin
          if (count_eff < FullCount) begin
            frame_d[32'(count_eff) * DBITS +: DBITS] = rx_byte;
            count_d = count_eff + 6'd1;
          end else begin
            // Frame already full and waiting to issue: nowhere to put the byte.
            overrun_d = 1'b1;
          end
        end
        if (count_q == FullCount) begin
          state_d     = StIssue;
          din_valid_d = 1'b1;
        end
      end
      StIssue: begin
        count_d = '0;
        state_d = StWaitCp;
      end
      StWaitCp: begin
        if (cp_dout_valid) begin
          result_d = cp_dout;
          state_d  = StSend;
        end
      end
      StSend: begin
        start_d = 1'b1;
        armed_d = 1'b0;
        state_d = StDrain;
      end
      StDrain: begin
        // armed_q keeps the first DRAIN cycle (the tx_start cycle) from exiting,
        // giving the transmitter a cycle to raise tx_busy.
        armed_d = 1'b1;
        if (armed_q && !tx_busy) begin
          state_d = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase

    if (rx_valid && (state_q != StCollect)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StCollect;
      count_q     <= '0;
      frame_q     <= '0;
      result_q    <= '0;
      din_valid_q <= 1'b0;
      start_q     <= 1'b0;
      overrun_q   <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      frame_q     <= frame_d;
      result_q    <= result_d;
      din_valid_q <= din_valid_d;
      start_q     <= start_d;
      overrun_q   <= overrun_d;
      armed_q     <= armed_d;
    end
  end

  assign cp_din       = frame_q;
  assign cp_din_valid = din_valid_q;
  assign tx_frame     = result_q;
  assign tx_start     = start_q;
  assign byte_count   = count_q;
  assign busy         = (state_q != StCollect);
  assign overrun      = overrun_q;

endmodule
